// File: rtl/plights_pkg.sv
// Shared mode encodings, direction type and init-pattern helper for the running-lights driver.
package plights_pkg;

  localparam logic [1:0] MODE_ROTL   = 2'd0;
  localparam logic [1:0] MODE_ROTR   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  // Widest pattern the helper can build; callers truncate to their own WIDTH.
  localparam int unsigned PAT_MAX = 64;

  typedef enum logic {DirUp, DirDown} dir_e;

  function automatic logic [PAT_MAX-1:0] init_pattern(input logic [1:0]  mode,
                                                       input int unsigned width);
    logic [PAT_MAX-1:0] pat;
    pat = '0;
    case (mode)
      MODE_ROTL, MODE_BOUNCE: pat = PAT_MAX'(1);
      MODE_ROTR:              pat = PAT_MAX'(1) << (width - 1);
      default:                pat = '0;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/plights_if.sv
// Control/LED bundle of the running-lights driver; duty exists only with PLIGHTS_PWM_EN.
interface plights_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] led;
  logic             step;

`ifdef PLIGHTS_PWM_EN
  logic [3:0]       duty;

  modport master (output en, mode, duty, input led, step);
  modport slave  (input en, mode, duty, output led, step);
`else
  modport master (output en, mode, input led, step);
  modport slave  (input en, mode, output led, step);
`endif

endinterface

// File: rtl/plights_prescaler.sv
// Divides enabled clock cycles by DIV into a single-cycle step tick.
module plights_prescaler #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned     CntW   = $clog2(DIV) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = en_i && (cnt_q == CntMax);
    if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/plights_multi.sv
// WIDTH-bit running-lights driver: rotate left/right, bounce and bar fill, one step per DIV
// enabled clocks. Optional PWM dimming of the LED output when PLIGHTS_PWM_EN is defined.
module plights_multi
  import plights_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 2
) (
  input logic       clk,
  input logic       rst,
  plights_if.slave  bus
);

  logic             tick;
  logic [WIDTH-1:0] pat_q, pat_d, init_pat;
  logic [1:0]       mode_q, mode_d;
  dir_e             dir_q, dir_d;
  logic             step_q;
  logic             pat_ok;

  plights_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (bus.en),
    .tick_o (tick)
  );

  // Same value on a mode change and on a same-mode reload, since then bus.mode == mode_q.
  assign init_pat = WIDTH'(init_pattern(bus.mode, WIDTH));

  always_comb begin
    case (mode_q)
      MODE_FILL: pat_ok = ((pat_q & (pat_q + WIDTH'(1))) == '0);
      default:   pat_ok = $onehot(pat_q);
    endcase
  end

  always_comb begin
    pat_d  = pat_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    if (tick) begin
      if (bus.mode != mode_q) begin
        mode_d = bus.mode;
        pat_d  = init_pat;
        dir_d  = DirUp;
      end else if (!pat_ok) begin
        pat_d = init_pat;
        dir_d = DirUp;
      end else begin
        case (mode_q)
          MODE_ROTL: pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
          MODE_ROTR: pat_d = {pat_q[0], pat_q[WIDTH-1:1]};
          MODE_BOUNCE: begin
            // Turning at an end moves off it on the same tick, so ends never repeat.
            if (dir_q == DirUp) begin
              if (pat_q[WIDTH-1]) begin
                dir_d = DirDown;
                pat_d = pat_q >> 1;
              end else begin
                pat_d = pat_q << 1;
              end
            end else begin
              if (pat_q[0]) begin
                dir_d = DirUp;
                pat_d = pat_q << 1;
              end else begin
                pat_d = pat_q >> 1;
              end
            end
          end
          default: pat_d = (&pat_q) ? '0 : {pat_q[WIDTH-2:0], 1'b1};
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= WIDTH'(1);
      dir_q  <= DirUp;
      mode_q <= MODE_ROTL;
      step_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      step_q <= tick;
    end
  end

  assign bus.step = step_q;

`ifdef PLIGHTS_PWM_EN
  logic [3:0]       pwm_cnt_q;
  logic [WIDTH-1:0] led_q;

  // Gated from pat_d so the new pattern shows in the same cycle as step.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= 4'd0;
      led_q     <= WIDTH'(1);
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
      led_q     <= pat_d & {WIDTH{pwm_cnt_q < bus.duty}};
    end
  end

  assign bus.led = led_q;
`else
  assign bus.led = pat_q;
`endif

endmodule

// File: tb/tb_plights_multi.sv
// Scoreboard bench for plights_multi (WIDTH=8/DIV=2 plus a WIDTH=2/DIV=1 instance).
// Covers the PWM stage as well when PLIGHTS_PWM_EN is defined.
module tb_plights_multi;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIV   = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  plights_if #(.WIDTH(WIDTH)) bus ();
  plights_if #(.WIDTH(2))     bus2 ();

  plights_multi #(.WIDTH(WIDTH), .DIV(DIV)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  plights_multi #(.WIDTH(2), .DIV(1)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [1:0] exp2_q[$];
  logic [7:0] e1;
  logic [1:0] e2;
  int         en_cnt = 0;
  logic       on1 = 1'b1;
  logic       on2 = 1'b1;
  logic [3:0] pwm_m = 4'd0;
  bit         rel = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_drain"}, exp_q.size(), 0);
  endtask

  // Monitor: inputs only change on negedge, so at posedge+1 they still hold the sampled values.
  always @(posedge clk) begin
    #1;
`ifdef PLIGHTS_PWM_EN
    on1   = rst || (pwm_m < bus.duty);
    on2   = rst || (pwm_m < bus2.duty);
    pwm_m = rst ? 4'd0 : pwm_m + 4'd1;
`endif
    if (rst) begin
      en_cnt = 0;
    end else begin
      if (bus.en) en_cnt++;
      if (bus.step) begin
        check_eq("step_gap", en_cnt, DIV);
        en_cnt = 0;
        check_eq("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e1 = exp_q.pop_front();
          check_eq("led", bus.led, on1 ? e1 : 8'h00);
        end
      end
      if (bus2.step) begin
        check_eq("sb2_nonempty", exp2_q.size() != 0, 1);
        if (exp2_q.size() != 0) begin
          e2 = exp2_q.pop_front();
          check_eq("led2", bus2.led, on2 ? e2 : 2'b00);
        end
      end
    end
  end

  // Narrow instance: BOUNCE with DIV=1 steps every cycle, alternating the two LEDs.
  initial begin
    bus2.en   = 1'b0;
    bus2.mode = 2'd2;
`ifdef PLIGHTS_PWM_EN
    bus2.duty = 4'd15;
`endif
    wait (rel);
    for (int i = 0; i < 8; i++) exp2_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
    bus2.en = 1'b1;
    repeat (8) @(negedge clk);
    bus2.en = 1'b0;
  end

  initial begin
    int lit;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.mode = 2'd0;
`ifdef PLIGHTS_PWM_EN
    bus.duty = 4'd15;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_led", bus.led, 8'h01);
    check_eq("rst_step", bus.step, 0);
    check_eq("rst_led2", bus2.led, 2'b01);

    // ROTL up to 04 on the second lap
    for (int i = 1; i <= 10; i++) exp_q.push_back(8'(1 << (i % 8)));
    rst    = 1'b0;
    bus.en = 1'b1;
    rel    = 1'b1;
    wait_drain("rotl");

    // ROTR: mode change loads the top bit
    bus.mode = 2'd1;
    for (int i = 0; i <= 8; i++) exp_q.push_back(8'(8'h80 >> (i % 8)));
    wait_drain("rotr");

    // BOUNCE: full period plus one
    bus.mode = 2'd2;
    for (int i = 0; i <= 7; i++) exp_q.push_back(8'(1 << i));
    for (int i = 6; i >= 0; i--) exp_q.push_back(8'(1 << i));
    exp_q.push_back(8'h02);
    wait_drain("bounce");

    // FILL: 00, 01 .. FF, 00
    bus.mode = 2'd3;
    exp_q.push_back(8'h00);
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'((1 << i) - 1));
    exp_q.push_back(8'h00);
    wait_drain("fill");

    // Freeze with the prescaler half way; resume must keep the remaining count
    bus.mode = 2'd0;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    wait_drain("pre_freeze");
    @(negedge clk);
    bus.en = 1'b0;
    repeat (7) begin
      @(negedge clk);
      check_eq("freeze_led", bus.led, on1 ? 8'h04 : 8'h00);
      check_eq("freeze_step", bus.step, 0);
    end
    bus.en = 1'b1;
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h10);
    wait_drain("resume");

    // Reset in BOUNCE while heading down, one cycle before a tick
    bus.mode = 2'd2;
    for (int i = 0; i <= 7; i++) exp_q.push_back(8'(1 << i));
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h20);
    wait_drain("bounce_down");
    @(negedge clk);
    rst      = 1'b1;
    bus.mode = 2'd0;
    @(negedge clk);
    check_eq("mid_rst_led", bus.led, 8'h01);
    check_eq("mid_rst_step", bus.step, 0);
    rst = 1'b0;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h04);
    wait_drain("after_rst");

`ifdef PLIGHTS_PWM_EN
    // Pattern frozen at 04; only the PWM gate changes the output
    bus.en   = 1'b0;
    bus.duty = 4'd8;
    @(negedge clk);
    lit = 0;
    repeat (32) begin
      @(negedge clk);
      if (bus.led != 8'h00) lit++;
    end
    check_eq("pwm_duty8", lit, 16);
    bus.duty = 4'd0;
    @(negedge clk);
    lit = 0;
    repeat (32) begin
      @(negedge clk);
      if (bus.led != 8'h00) lit++;
    end
    check_eq("pwm_duty0", lit, 0);
`endif

    check_eq("sb_left", exp_q.size(), 0);
    check_eq("sb2_left", exp2_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
